// File: rtl/iter_div_pkg.sv
// -----------------------------------------------------------------------------
// iter_div_pkg
// Shared types and constants for the iterative restoring divider.
//   div_state_e        : controller states (IDLE, RUN, DONE)
//   DIV_WIDTH_DEFAULT  : default operand/result width in bits
// -----------------------------------------------------------------------------
package iter_div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage : iter_div_pkg

// File: rtl/subtractor.sv
// -----------------------------------------------------------------------------
// subtractor
// Unsigned W-bit trial subtractor used by the divider's restoring step.
//   a, b        : unsigned operands
//   diff        : a - b, modulo 2**W
//   borrow_out  : 1 when b > a (the trial subtraction went negative)
// -----------------------------------------------------------------------------
module subtractor #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  // Widening by one bit turns the MSB of the result into the borrow.
  assign {borrow_out, diff} = {1'b0, a} - {1'b0, b};

endmodule : subtractor

// File: rtl/iter_divider.sv
// -----------------------------------------------------------------------------
// iter_divider
// Unsigned iterative restoring divider, one quotient bit per clock.
//   clk          : clock, all state updates on the rising edge
//   rst_n        : asynchronous active-low reset
//   start        : begin a division (sampled only while ready=1)
//   dividend     : unsigned dividend, captured on the accepting edge
//   divisor      : unsigned divisor, captured on the accepting edge
//   ready        : high only while idle
//   done         : one-cycle pulse marking valid results
//   quotient     : registered quotient, held until the next completion
//   remainder    : registered remainder, held until the next completion
//   div_by_zero  : registered flag, valid with done
// A zero divisor bypasses the iteration and completes on the next cycle with
// quotient all ones and remainder equal to the dividend.
// -----------------------------------------------------------------------------
module iter_divider
  import iter_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   prem_q, prem_d;       // partial remainder
  logic [WIDTH-1:0] q_q, q_d;             // dividend in, quotient bits shift in
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  // Restoring step datapath.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH:0]   step_prem;
  logic [WIDTH-1:0] step_q;

  assign shifted = {prem_q[WIDTH-1:0], q_q[WIDTH-1]};

  subtractor #(.W(WIDTH + 1)) u_sub (
    .a          (shifted),
    .b          ({1'b0, dvsr_q}),
    .diff       (diff),
    .borrow_out (borrow)
  );

  // No borrow: the divisor fits, keep the difference and shift in a 1.
  assign step_prem = borrow ? shifted : diff;
  assign step_q    = {q_q[WIDTH-2:0], ~borrow};

  // After every restoring step the partial remainder is below the divisor, so
  // its MSB is always 0; it only exists to hold the shifted-out bit transiently.
  logic unused_prem_msb;
  assign unused_prem_msb = prem_q[WIDTH];

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    prem_d      = prem_q;
    q_d         = q_q;
    dvsr_d      = dvsr_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = RUN;
            prem_d  = '0;
            q_d     = dividend;
            dvsr_d  = divisor;
            cnt_d   = CNT_W'(WIDTH - 1);
          end
        end
      end
      RUN: begin
        prem_d = step_prem;
        q_d    = step_q;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d     = DONE;
          quotient_d  = step_q;
          remainder_d = step_prem[WIDTH-1:0];
          dbz_d       = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with
    // the state register.
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the always_comb above uses blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prem_q      <= '0;
      q_q         <= '0;
      dvsr_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prem_q      <= prem_d;
      q_q         <= q_d;
      dvsr_q      <= dvsr_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule : iter_divider

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (WIDTH >= 2).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  request to begin a division; it is sampled only when ready=1.
REQ-005 The block SHALL have port dividend  input  WIDTH  unsigned dividend, captured on the accepting edge.
REQ-006 The block SHALL have port divisor  input  WIDTH  unsigned divisor, captured on the accepting edge.
REQ-007 The block SHALL have port ready  output  1  high only in state IDLE.
REQ-008 The block SHALL have port done  output  1  single-cycle pulse marking valid results.
REQ-009 The block SHALL have port quotient  output  WIDTH  registered quotient.
REQ-010 The block SHALL have port remainder  output  WIDTH  registered remainder.
REQ-011 The block SHALL have port div_by_zero  output  1  registered flag, valid with done.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 Acceptance SHALL occur on the rising edge where state=IDLE and start=1; that edge is E0.
REQ-014 At E0 with divisor!=0, the block SHALL load the partial remainder (WIDTH+1 bits) with 0, the quotient shift register with dividend and the divisor register with divisor, set the iteration counter to WIDTH-1, and enter RUN.
REQ-015 Each RUN edge SHALL perform one restoring step:
- shifted = {prem[WIDTH-1:0], q[WIDTH-1]}
- diff = shifted - {1'b0, divisor} via the subtractor
- if borrow_out=0: prem=diff and the shifted-in quotient LSB is 1
- otherwise: prem=shifted and the quotient LSB is 0
- q is shifted left.
REQ-016 RUN SHALL last exactly WIDTH edges (E1..EW); on the edge where the counter equals 0, the state SHALL become DONE.
REQ-017 done SHALL be 1 for exactly the one cycle in DONE; the next edge SHALL return the state to IDLE (ready=1).
REQ-018 Latency SHALL be: done high during the cycle after edge E(WIDTH), and the result visible WIDTH+1 edges after start is sampled.
REQ-019 quotient and remainder SHALL be updated only on entry to DONE and SHALL hold until the next entry to DONE.
REQ-020 At E0 with divisor=0, the block SHALL go directly to DONE with quotient set to all ones, remainder set to dividend and div_by_zero set to 1.
REQ-021 Any non-zero-divisor completion SHALL clear div_by_zero.
REQ-022 start SHALL be ignored in RUN and DONE; operand changes after E0 SHALL have no effect.
REQ-023 Back-to-back operation SHALL have a minimum issue interval of WIDTH+2 cycles (start is held across the DONE→IDLE edge).
REQ-024 dividend < divisor SHALL give quotient 0 and remainder = dividend; dividend = all ones with divisor = 1 SHALL give quotient all ones and remainder 0.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously force: state=IDLE, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, and counter and internal registers to 0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation; no done SHALL follow, and the first start after deassertion SHALL be accepted normally.

Structure
REQ-027 Package iter_div_pkg SHALL hold the state typedef div_state_e (IDLE, RUN, DONE) and the constant DIV_WIDTH_DEFAULT = 32.
REQ-028 The block SHALL instantiate exactly one sub-module, subtractor, with WIDTH+1, for the trial subtraction; no other arithmetic operator SHALL be used for the step.
REQ-029 The counter SHALL be $clog2(WIDTH) bits wide.

Verification
REQ-030 Scenario: dividend=100, divisor=7, WIDTH=32 -> done exactly 33 edges after E0, quotient=14, remainder=2, div_by_zero=0.
REQ-031 Scenario: dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0; then dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-032 Scenario: dividend=0x1234, divisor=0 -> done on the cycle after E0, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
REQ-033 Scenario: start held high continuously with operands changed mid-RUN -> the first result is unaffected, the second acceptance occurs only at the edge after DONE, and exactly one done pulse is produced per operation.
REQ-034 Scenario: rst_n pulled low at E10 of a run of 1000/3 -> all outputs are 0 and ready=1 immediately, with no done; a subsequent 1000/3 gives quotient=333, remainder=1.
REQ-035 Scenario: 10k random unsigned pairs, including divisor=0 -> quotient and remainder match the reference model, and outputs hold stable between done pulses.
